// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus signals of the memory access unit.
// slave is the unit's view; master is the control-unit/memory environment.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_fetch;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        err;
  logic [31:0] instr_out;
  logic [31:0] load_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req_valid, req_fetch, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output busy, done, misaligned, err, instr_out, load_data,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_fetch, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  busy, done, misaligned, err, instr_out, load_data,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: serialises fetch/load/store requests onto a simple
// strobe/ready memory bus with lane steering, extension and a ready timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              fetch_q, write_q, unsigned_q;
  logic [1:0]        size_q, offset_q;
  logic              busy_q, done_q, misaligned_q, err_q;
  logic              mem_en_q, mem_we_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_addr_q, mem_wdata_q, instr_q, load_q;

  logic              acc_word, acc_half, acc_misaligned;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic [31:0]       lane, load_ext;

  // Decode of the incoming request, used only on the acceptance edge.
  always_comb begin
    acc_word       = bus.req_fetch | bus.req_size[1];
    acc_half       = ~acc_word & bus.req_size[0];
    acc_misaligned = acc_word ? (bus.req_addr[1:0] != 2'b00) : (acc_half & bus.req_addr[0]);
    if (acc_word) begin
      acc_be    = 4'b1111;
      acc_wdata = bus.req_wdata;
    end else if (acc_half) begin
      acc_be    = 4'b0011 << {bus.req_addr[1], 1'b0};
      acc_wdata = bus.req_wdata << {bus.req_addr[1], 4'b0000};
    end else begin
      acc_be    = 4'b0001 << bus.req_addr[1:0];
      acc_wdata = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
    end
  end

  // Aligned accesses guarantee offset_q is 0 for words and even for halfwords.
  always_comb begin
    lane = bus.mem_rdata >> {offset_q, 3'b000};
    if (size_q[1]) begin
      load_ext = lane;
    end else if (size_q[0]) begin
      load_ext = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
    end else begin
      load_ext = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fetch_q      <= 1'b0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      offset_q     <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      instr_q      <= RESET_INSTR;
      load_q       <= 32'h0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            busy_q     <= 1'b1;
            fetch_q    <= bus.req_fetch;
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            size_q     <= acc_word ? 2'b10 : bus.req_size;
            offset_q   <= bus.req_addr[1:0];
            if (acc_misaligned) begin
              state_q      <= StResp;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= StReq;
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.req_write & ~bus.req_fetch;
              mem_be_q    <= acc_be;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q <= acc_wdata;
            end
          end
        end
        StReq, StWait: begin
          if (bus.mem_ready) begin
            state_q  <= StResp;
            done_q   <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (fetch_q) begin
              instr_q <= bus.mem_rdata;
            end else if (!write_q) begin
              load_q <= load_ext;
            end
          end else if (state_q == StReq) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            // cnt_q counts completed wait cycles minus one; this is the last allowed one.
            state_q  <= StResp;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.misaligned = misaligned_q;
  assign bus.err        = err_q;
  assign bus.instr_out  = instr_q;
  assign bus.load_data  = load_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses compared against a behavioural model of lanes, extension and timing.
module tb_mem_access_unit;

  localparam int unsigned T = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] exp_instr = 32'h0000_0013;
  logic [31:0] exp_load = 32'h0;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES(T),
    .RESET_INSTR   (32'h0000_0013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model of a load result: pick the addressed lane and extend it.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*addr[1:0] +: 8];
    h = rdata[16*addr[1] +: 16];
    if (size[1]) return rdata;
    if (size == 2'b01) return uns ? {16'h0, h} : 32'($signed(h));
    return uns ? {24'h0, b} : 32'($signed(b));
  endfunction

  // Drives one request from a point just after a rising edge; d is the number of
  // cycles after the REQ cycle before mem_ready (0 = ready in REQ, >T = never).
  task automatic do_access(input logic fetch, input logic write, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int d, input logic poke);
    logic        is_word, is_half, mis, exp_we, exp_err;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    int          kd;
    is_word = fetch || size[1];
    is_half = !is_word && (size == 2'b01);
    mis     = is_word ? (addr[1:0] != 2'b00) : (is_half && addr[0]);
    ebe     = is_word ? 4'hF : is_half ? 4'(4'b0011 << (2 * addr[1])) : 4'(4'b0001 << addr[1:0]);
    ewd     = is_word ? wdata : is_half ? (wdata << (16 * addr[1])) : (wdata << (8 * addr[1:0]));
    eaddr   = {addr[31:2], 2'b00};
    exp_we  = write && !fetch;

    bus.req_valid = 1'b1;
    bus.req_fetch = fetch;
    bus.req_write = write;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = poke && !mis;
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    check("busy_accept", bus.busy, 1);

    if (mis) begin
      check("mis_done", bus.done, 1);
      check("mis_flag", bus.misaligned, 1);
      check("mis_err", bus.err, 0);
      check("mis_en", bus.mem_en, 0);
      @(posedge clk);
      #1;
      check("mis_done_drop", bus.done, 0);
      check("mis_busy_drop", bus.busy, 0);
      check("mis_flag_drop", bus.misaligned, 0);
      check("mis_en_after", bus.mem_en, 0);
      check("mis_load_kept", bus.load_data, exp_load);
      check("mis_instr_kept", bus.instr_out, exp_instr);
      return;
    end

    check("req_en", bus.mem_en, 1);
    check("req_we", bus.mem_we, 32'(exp_we));
    check("req_be", bus.mem_be, 32'(ebe));
    check("req_addr", bus.mem_addr, eaddr);
    check("req_wdata", bus.mem_wdata, ewd);
    check("req_done_low", bus.done, 0);

    exp_err = (d > int'(T));
    kd = exp_err ? int'(T) : d;
    for (int k = 0; k <= kd; k++) begin
      bus.mem_ready = (k == d);
      bus.mem_rdata = (k == d) ? rdata : $urandom;
      @(posedge clk);
      #1;
      if (k < kd) begin
        check("wait_en", bus.mem_en, 1);
        check("wait_addr", bus.mem_addr, eaddr);
        check("wait_be", bus.mem_be, 32'(ebe));
        check("wait_wdata", bus.mem_wdata, ewd);
        check("wait_done_low", bus.done, 0);
      end
    end
    bus.mem_ready = 1'b0;
    check("resp_done", bus.done, 1);
    check("resp_err", bus.err, 32'(exp_err));
    check("resp_mis", bus.misaligned, 0);
    check("resp_en", bus.mem_en, 0);
    check("resp_we", bus.mem_we, 0);
    if (!exp_err) begin
      if (fetch) exp_instr = rdata;
      else if (!write) exp_load = model_load(size, uns, addr, rdata);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("end_done_drop", bus.done, 0);
    check("end_busy_drop", bus.busy, 0);
    check("end_err_drop", bus.err, 0);
    check("end_instr", bus.instr_out, exp_instr);
    check("end_load", bus.load_data, exp_load);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_fetch = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_en", bus.mem_en, 0);
    check("rst_be", bus.mem_be, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_instr", bus.instr_out, 32'h0000_0013);
    check("rst_load", bus.load_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset release with a fetch already requested.
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0050_0093, 0, 1'b0);
    check("fetch_instr", bus.instr_out, 32'h0050_0093);
    do_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check("lb_signed", bus.load_data, 32'hFFFF_FF80);
    do_access(1'b0, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_1234, 2, 1'b0);
    check("lb_unsigned", bus.load_data, 32'h0000_0080);
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1'b0);
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 0, 1'b0);
    check("mis_load_val", bus.load_data, 32'h0000_0080);
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, T + 3, 1'b1);
    do_access(1'b0, 1'b0, 2'b01, 1'b0, 32'h406, 32'h0, 32'h9ABC_0000, T, 1'b1);
    check("lh_last_wait", bus.load_data, 32'hFFFF_9ABC);

    // Reset mid-wait: outputs must drop before the next edge.
    bus.req_valid = 1'b1;
    bus.req_fetch = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h800;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_en", bus.mem_en, 1);
    reset = 1'b1;
    #1;
    check("midrst_en", bus.mem_en, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_instr", bus.instr_out, 32'h0000_0013);
    check("midrst_load", bus.load_data, 0);
    exp_instr = 32'h0000_0013;
    exp_load = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int          d;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      check("idle_ready_instr", bus.instr_out, exp_instr);
      check("idle_ready_load", bus.load_data, exp_load);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 7) == 0) ? int'(T) + 1 + int'($urandom_range(0, 2))
                                       : int'($urandom_range(0, 5));
      do_access(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                d, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
